// File: rtl/full_mat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : full_mat_pkg
// Description : Shared types and default sizes for full_mat and its loader.
// Revision    : 1.0 - initial release
// ============================================================================
package full_mat_pkg;

    localparam int MAT_N      = 4;
    localparam int MAT_DATA_W = 32;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    typedef logic [MAT_N*MAT_N-1:0][MAT_DATA_W-1:0] mat_t;

endpackage
`default_nettype wire

// File: rtl/full_mat_bank.sv
`default_nettype none
// ============================================================================
// Module      : full_mat_bank
// Description : One N*N element register bank, indexed write, flat read.
// Revision    : 1.0 - initial release
// ============================================================================
module full_mat_bank
    import full_mat_pkg::*;
#(
    parameter int N      = MAT_N,
    parameter int DATA_W = MAT_DATA_W,
    parameter int IDX_W  = $clog2(N*N)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_we,
    input  logic [IDX_W-1:0]         i_idx,
    input  logic [DATA_W-1:0]        i_data,
    output logic [N*N*DATA_W-1:0]    o_data
);

    logic [N*N-1:0][DATA_W-1:0] r_mem;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem <= '0;
        end else if (i_we) begin
            r_mem[i_idx] <= i_data;
        end
    end

    assign o_data = r_mem;

endmodule
`default_nettype wire

// File: rtl/full_mat_loader.sv
`default_nettype none
// ============================================================================
// Module      : full_mat_loader
// Description : Ping-pong staging of a row-major element stream into full
//               N*N matrices presented to full_mat over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module full_mat_loader
    import full_mat_pkg::*;
#(
    parameter int N      = MAT_N,
    parameter int DATA_W = MAT_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic                     mat_valid,
    output logic [N*N*DATA_W-1:0]    mat_data,
    input  logic                     mat_ready,
    output logic                     frame_err,
    output logic [15:0]              frame_cnt
);

    localparam int               IDX_W      = $clog2(N*N);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N*N-1);

    bank_state_t             r_state     [2];
    bank_state_t             w_state_nxt [2];
    logic                    r_wr_bank;
    logic                    w_wr_bank_nxt;
    logic                    r_rd_bank;
    logic                    w_rd_bank_nxt;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic                    r_frame_err;
    logic                    w_frame_err_nxt;
    logic [15:0]             r_frame_cnt;
    logic [15:0]             w_frame_cnt_nxt;
    logic                    w_accept;
    logic                    w_xfer;
    logic [1:0]              w_we;
    logic [N*N*DATA_W-1:0]   w_rdata [2];

    // Handshake outputs depend only on registered bank state and pointers.
    assign in_ready  = (r_state[r_wr_bank] != FULL);
    assign mat_valid = (r_state[r_rd_bank] == FULL);
    assign mat_data  = w_rdata[r_rd_bank];
    assign frame_err = r_frame_err;
    assign frame_cnt = r_frame_cnt;

    assign w_accept  = in_valid && in_ready;
    assign w_xfer    = mat_valid && mat_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state[0]  <= EMPTY;
            r_state[1]  <= EMPTY;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_idx       <= '0;
            r_frame_err <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_state[0]  <= w_state_nxt[0];
            r_state[1]  <= w_state_nxt[1];
            r_wr_bank   <= w_wr_bank_nxt;
            r_rd_bank   <= w_rd_bank_nxt;
            r_idx       <= w_idx_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt[0]  = r_state[0];
        w_state_nxt[1]  = r_state[1];
        w_wr_bank_nxt   = r_wr_bank;
        w_rd_bank_nxt   = r_rd_bank;
        w_idx_nxt       = r_idx;
        w_frame_err_nxt = 1'b0;
        w_frame_cnt_nxt = r_frame_cnt;
        w_we            = 2'b00;

        if (w_accept) begin
            w_we[r_wr_bank] = 1'b1;
            if (r_idx == c_last_idx) begin
                // A missing last still completes the matrix, but is flagged.
                w_state_nxt[r_wr_bank] = FULL;
                w_idx_nxt              = '0;
                w_wr_bank_nxt          = ~r_wr_bank;
                w_frame_err_nxt        = ~in_last;
            end else if (in_last) begin
                w_state_nxt[r_wr_bank] = EMPTY;
                w_idx_nxt              = '0;
                w_frame_err_nxt        = 1'b1;
            end else begin
                w_state_nxt[r_wr_bank] = FILLING;
                w_idx_nxt              = r_idx + 1'b1;
            end
        end

        // Accept targets a non-FULL bank and transfer a FULL one, so both
        // can be applied in the same cycle without colliding.
        if (w_xfer) begin
            w_state_nxt[r_rd_bank] = EMPTY;
            w_rd_bank_nxt          = ~r_rd_bank;
            w_frame_cnt_nxt        = r_frame_cnt + 16'd1;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        full_mat_bank #(
            .N      (N),
            .DATA_W (DATA_W)
        ) u_bank (
            .clk     (clk),
            .reset_n (reset_n),
            .i_we    (w_we[gi]),
            .i_idx   (r_idx),
            .i_data  (in_data),
            .o_data  (w_rdata[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_full_mat_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_full_mat_loader
// Description : Scoreboard bench for full_mat_loader with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_full_mat_loader;
    import full_mat_pkg::*;

    localparam int NE = MAT_N*MAT_N;
    localparam int MW = NE*MAT_DATA_W;

    logic                  clk;
    logic                  reset_n;
    logic                  in_valid;
    logic [MAT_DATA_W-1:0] in_data;
    logic                  in_last;
    logic                  in_ready;
    logic                  mat_valid;
    logic [MW-1:0]         mat_data;
    logic                  mat_ready;
    logic                  frame_err;
    logic [15:0]           frame_cnt;

    int   n_checks = 0;
    int   n_errors = 0;
    mat_t exp_q [$];

    full_mat_loader #(.N(MAT_N), .DATA_W(MAT_DATA_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .mat_valid (mat_valid),
        .mat_data  (mat_data),
        .mat_ready (mat_ready),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic mat_t mk(input int base);
        mat_t m;
        for (int k = 0; k < NE; k++) m[k] = MAT_DATA_W'(base + k);
        return m;
    endfunction

    // Element k of matrix 'base' carries base+k.
    task automatic send(input logic [MAT_DATA_W-1:0] d, input logic l);
        int w;
        w        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_mat(input int base, input int count, input int last_at);
        for (int k = 0; k < count; k++) send(MAT_DATA_W'(base + k), (k == last_at));
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", MW'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every transfer must match the oldest expected matrix.
    initial begin
        mat_t e;
        forever begin
            @(negedge clk);
            if (reset_n && mat_valid && mat_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_matrix", mat_data, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("mat_data", mat_data, e);
                end
            end
        end
    end

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        mat_ready = 1'b0;
        reset_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mat_valid", mat_valid, 0);
        chk("rst_mat_data", mat_data, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single matrix, valid one cycle after the final accept.
        mat_ready = 1'b1;
        exp_q.push_back(mk(1));
        send_mat(1, NE, NE-1);
        chk("single_valid", mat_valid, 1);
        chk("single_err", frame_err, 0);
        drain();
        chk("single_cnt", frame_cnt, 1);
        chk("single_valid_drop", mat_valid, 0);

        // Back-pressure: third matrix stalls until the consumer drains.
        do_reset();
        mat_ready = 1'b0;
        exp_q.push_back(mk(100));
        exp_q.push_back(mk(200));
        exp_q.push_back(mk(300));
        fork
            begin
                send_mat(100, NE, NE-1);
                send_mat(200, NE, NE-1);
                send_mat(300, NE, NE-1);
            end
            begin
                repeat (20) @(negedge clk);
                chk("bp_hold_mid", mat_data, mk(100));
                repeat (20) @(negedge clk);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_mat_valid", mat_valid, 1);
                chk("bp_hold", mat_data, mk(100));
                @(posedge clk);
                #1;
                mat_ready = 1'b1;
                chk("bp_ready_xfer_cycle", in_ready, 0);
                @(posedge clk);
                #1;
                chk("bp_ready_rise", in_ready, 1);
            end
        join
        drain();
        chk("bp_cnt", frame_cnt, 3);

        // Early last discards the partial matrix.
        do_reset();
        mat_ready = 1'b1;
        send_mat(900, 5, 4);
        chk("early_err", frame_err, 1);
        chk("early_no_valid", mat_valid, 0);
        @(posedge clk);
        #1;
        chk("early_err_pulse", frame_err, 0);
        exp_q.push_back(mk(400));
        send_mat(400, NE, NE-1);
        chk("early_next_err", frame_err, 0);
        drain();
        chk("early_cnt", frame_cnt, 1);

        // Missing last still delivers the matrix.
        do_reset();
        mat_ready = 1'b1;
        exp_q.push_back(mk(500));
        send_mat(500, NE, -1);
        chk("miss_err", frame_err, 1);
        chk("miss_valid", mat_valid, 1);
        @(posedge clk);
        #1;
        chk("miss_err_once", frame_err, 0);
        drain();
        chk("miss_cnt", frame_cnt, 1);

        // Final accept into bank 1 coincides with transfer out of bank 0.
        do_reset();
        mat_ready = 1'b0;
        exp_q.push_back(mk(600));
        exp_q.push_back(mk(700));
        send_mat(600, NE, NE-1);
        send_mat(700, NE-1, -1);
        mat_ready = 1'b1;
        send(MAT_DATA_W'(700 + NE - 1), 1'b1);
        chk("sim_cnt", frame_cnt, 1);
        chk("sim_valid", mat_valid, 1);
        chk("sim_data", mat_data, mk(700));
        chk("sim_in_ready", in_ready, 1);
        drain();
        chk("sim_cnt2", frame_cnt, 2);

        // Reset mid-fill, without a clean reset beforehand.
        mat_ready = 1'b1;
        send_mat(800, 7, -1);
        reset_n = 1'b0;
        #2;
        chk("mid_in_ready", in_ready, 1);
        chk("mid_mat_valid", mat_valid, 0);
        chk("mid_mat_data", mat_data, 0);
        chk("mid_frame_err", frame_err, 0);
        chk("mid_frame_cnt", frame_cnt, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(mk(1000));
        send_mat(1000, NE, NE-1);
        drain();
        chk("mid_cnt", frame_cnt, 1);
        chk("queue_empty", MW'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
